lsu_ctrl: RTL

- Load/store controller directly upstream of the byte-addressed data memory (256 x 8, little-endian, combinational 32-bit read at raddr..raddr+3, 32-bit write on negedge clk when memwr=1).
- Accepts one load/store request at a time from the execute stage.
- Performs byte, halfword and word accesses. Loads are sign- or zero-extended. Sub-word stores use read-modify-write, because the memory only writes whole 4-byte groups.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.

---
 rtl/lsu_ctrl_if.sv | 27 ++
 rtl/lsu_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response bundle between the execute stage and the load/store controller.
// Latency: none (wires only).
// Backpressure: req_ready gates acceptance; responses are unconditioned one-cycle pulses.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Execute stage side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a byte-addressed data memory (byte/half/word, RMW sub-word stores).
// Latency (accept edge to edge ending resp_valid): error 1, load 2, word store 2, sub-word store 3.
// Backpressure: one request in flight; req_ready only in IDLE; resp_valid has no backpressure.
// Ports: clk, rst_n; lsu (slave side of lsu_ctrl_if: req_* in, req_ready/resp_* out);
//        mem_raddr/mem_waddr/mem_in/mem_memwr to memory, mem_out combinational read data back.
module lsu_ctrl #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   lsu,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_in,
    output logic        mem_memwr,
    input  logic [31:0] mem_out
);

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 4);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wbuf_q;    // holds store data, later the merged RMW word
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] rmw_merge;

    // Request legality, evaluated on the live request while in IDLE.
    always_comb begin
        req_err = 1'b0;
        if (lsu.req_size == 2'b11)                                 req_err = 1'b1;
        if (lsu.req_size == 2'b01 && lsu.req_addr[0])              req_err = 1'b1;
        if (lsu.req_size == 2'b10 && lsu.req_addr[1:0] != 2'b00)   req_err = 1'b1;
        if (lsu.req_addr > LAST_ADDR)                              req_err = 1'b1;
    end

    // Load data extraction and extension from the little-endian read word.
    always_comb begin
        load_ext = mem_out;
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{mem_out[7]}},  mem_out[7:0]}
                                         : {24'h0, mem_out[7:0]};
            2'b01:   load_ext = signed_q ? {{16{mem_out[15]}}, mem_out[15:0]}
                                         : {16'h0, mem_out[15:0]};
            default: load_ext = mem_out;
        endcase
    end

    // Sub-word store: keep the upper bytes exactly as read so the 4-byte write
    // rewrites them with their current values.
    always_comb begin
        rmw_merge = mem_out;
        case (size_q)
            2'b00:   rmw_merge = {mem_out[31:8],  wbuf_q[7:0]};
            2'b01:   rmw_merge = {mem_out[31:16], wbuf_q[15:0]};
            default: rmw_merge = mem_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wbuf_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        size_q   <= lsu.req_size;
                        signed_q <= lsu.req_signed;
                        addr_q   <= lsu.req_addr;
                        wbuf_q   <= lsu.req_wdata;
                        rdata_q  <= 32'h0;          // stores and errors return zero
                        err_q    <= req_err;
                        // Direction only steers the state path, so it is not kept.
                        if (req_err)                      state <= RESP;
                        else if (!lsu.req_we)             state <= RD;
                        else if (lsu.req_size == 2'b10)   state <= WR;
                        else                              state <= RMW_RD;
                    end
                end
                RD: begin
                    rdata_q <= load_ext;
                    state   <= RESP;
                end
                RMW_RD: begin
                    wbuf_q <= rmw_merge;
                    state  <= WR;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so they cannot glitch;
    // async reset of the state drops mem_memwr before the write negedge.
    assign lsu.req_ready  = (state == IDLE);
    assign lsu.resp_valid = (state == RESP);
    assign lsu.resp_rdata = rdata_q;
    assign lsu.resp_err   = err_q;
    assign mem_memwr      = (state == WR);
    assign mem_raddr      = addr_q;
    assign mem_waddr      = addr_q;
    assign mem_in         = wbuf_q;

endmodule
